pe_array_ibuf: RTL and testbench



---
 rtl/pe_array_ibuf.sv | 125 ++++++++++++
 tb/tb_pe_array_ibuf.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ibuf.sv
// pe_array_ibuf: CP-to-PE-array instruction broadcast FIFO with NOP bubbles.
// Optional zero-latency empty bypass enabled by defining PE_IBUF_BYPASS_EN.

`ifndef DEF_PE_INS_WIDTH
`define DEF_PE_INS_WIDTH 32
`endif

module pe_array_ibuf #(
    parameter int DEPTH     = 4,
    parameter int INS_WIDTH = `DEF_PE_INS_WIDTH
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    input  logic                       iFlush,
    input  logic                       iStall,
    input  logic                       iCP_Valid,
    output logic                       oCP_Ready,
    input  logic [INS_WIDTH-1:0]       iCP_Instruction,
    input  logic [1:0]                 iCP_Predication,
    input  logic [1:0]                 iCP_Data_Selection,
    output logic [INS_WIDTH-1:0]       oIBUF_IF_Instruction,
    output logic [1:0]                 oIBUF_IF_Predication,
    output logic [1:0]                 oIBUF_IF_Data_Selection,
    output logic                       oIBUF_IF_Valid,
    output logic [$clog2(DEPTH):0]     oLevel
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [INS_WIDTH-1:0] ins;
        logic [1:0]           pred;
        logic [1:0]           sel;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          cp_entry;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            empty;
    logic            full;
    logic            bypass;
    logic            push;
    logic            pop;

    assign cp_entry = '{ins: iCP_Instruction,
                        pred: iCP_Predication,
                        sel: iCP_Data_Selection};
    assign head     = mem[rd_ptr];

    assign empty     = (count == '0);
    assign full      = (count == LW'(DEPTH));
    assign oCP_Ready = !full;
    assign oLevel    = count;

`ifdef PE_IBUF_BYPASS_EN
    // An empty, unstalled buffer forwards the CP entry straight through.
    assign bypass = empty && iCP_Valid && !iStall && !iFlush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry is consumed by the IF stage directly, never stored.
    assign push = iCP_Valid && oCP_Ready && !iFlush && !bypass;
    assign pop  = !empty && !iStall && !iFlush;

    // Entry storage; written only on an accepted push.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= cp_entry;
        end
    end

    // Pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iFlush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output mux: head entry, optional bypass, otherwise a NOP bubble.
    always_comb begin
        oIBUF_IF_Instruction    = '0;
        oIBUF_IF_Predication    = 2'b00;
        oIBUF_IF_Data_Selection = 2'b00;
        oIBUF_IF_Valid          = 1'b0;
        if (!empty) begin
            oIBUF_IF_Instruction    = head.ins;
            oIBUF_IF_Predication    = head.pred;
            oIBUF_IF_Data_Selection = head.sel;
            oIBUF_IF_Valid          = 1'b1;
        end else if (bypass) begin
            oIBUF_IF_Instruction    = iCP_Instruction;
            oIBUF_IF_Predication    = iCP_Predication;
            oIBUF_IF_Data_Selection = iCP_Data_Selection;
            oIBUF_IF_Valid          = 1'b1;
        end
    end

endmodule

// File: tb/tb_pe_array_ibuf.sv
// tb_pe_array_ibuf: directed table-driven bench for pe_array_ibuf.
// Bypass expectations follow PE_IBUF_BYPASS_EN when it is defined.

module tb_pe_array_ibuf;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic          iClk;
    logic          iReset_n;
    logic          iFlush;
    logic          iStall;
    logic          iCP_Valid;
    logic          oCP_Ready;
    logic [W-1:0]  iCP_Instruction;
    logic [1:0]    iCP_Predication;
    logic [1:0]    iCP_Data_Selection;
    logic [W-1:0]  oIBUF_IF_Instruction;
    logic [1:0]    oIBUF_IF_Predication;
    logic [1:0]    oIBUF_IF_Data_Selection;
    logic          oIBUF_IF_Valid;
    logic [2:0]    oLevel;

    int checks = 0;
    int errors = 0;

    pe_array_ibuf #(.DEPTH(DEPTH), .INS_WIDTH(W)) dut (
        .iClk                    (iClk),
        .iReset_n                (iReset_n),
        .iFlush                  (iFlush),
        .iStall                  (iStall),
        .iCP_Valid               (iCP_Valid),
        .oCP_Ready               (oCP_Ready),
        .iCP_Instruction         (iCP_Instruction),
        .iCP_Predication         (iCP_Predication),
        .iCP_Data_Selection      (iCP_Data_Selection),
        .oIBUF_IF_Instruction    (oIBUF_IF_Instruction),
        .oIBUF_IF_Predication    (oIBUF_IF_Predication),
        .oIBUF_IF_Data_Selection (oIBUF_IF_Data_Selection),
        .oIBUF_IF_Valid          (oIBUF_IF_Valid),
        .oLevel                  (oLevel)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic         valid;
        logic         stall;
        logic         flush;
        logic [W-1:0] ins;
        logic [1:0]   pred;
        logic [1:0]   sel;
        logic         e_valid;
        logic [W-1:0] e_ins;
        logic [1:0]   e_pred;
        logic [1:0]   e_sel;
        logic [2:0]   e_level;
        logic         e_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, input logic s, input logic f,
        input logic [W-1:0] i, input logic [1:0] p, input logic [1:0] d,
        input logic ev, input logic [W-1:0] ei, input logic [1:0] ep,
        input logic [1:0] ed, input logic [2:0] el, input logic er);
        vec_t r;
        r.valid = v;  r.stall = s;  r.flush = f;
        r.ins = i;    r.pred = p;   r.sel = d;
        r.e_valid = ev; r.e_ins = ei; r.e_pred = ep;
        r.e_sel = ed; r.e_level = el; r.e_ready = er;
        return r;
    endfunction

    task automatic check(input string name, input logic ev,
                         input logic [W-1:0] ei, input logic [1:0] ep,
                         input logic [1:0] ed, input logic [2:0] el,
                         input logic er);
        checks++;
        if (oIBUF_IF_Valid !== ev || oIBUF_IF_Instruction !== ei ||
            oIBUF_IF_Predication !== ep || oIBUF_IF_Data_Selection !== ed ||
            oLevel !== el || oCP_Ready !== er) begin
            errors++;
            $display("FAIL %s: got v=%b ins=%h p=%b d=%b lvl=%0d rdy=%b want v=%b ins=%h p=%b d=%b lvl=%0d rdy=%b",
                     name, oIBUF_IF_Valid, oIBUF_IF_Instruction,
                     oIBUF_IF_Predication, oIBUF_IF_Data_Selection,
                     oLevel, oCP_Ready, ev, ei, ep, ed, el, er);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic f,
                         input logic [W-1:0] i, input logic [1:0] p,
                         input logic [1:0] d);
        iCP_Valid          = v;
        iStall             = s;
        iFlush             = f;
        iCP_Instruction    = i;
        iCP_Predication    = p;
        iCP_Data_Selection = d;
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        // Fill with stall, over-push when full
        vecs.push_back(mk(1,1,0,32'h11,2'b01,2'b10, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        vecs.push_back(mk(1,1,0,32'h22,2'b10,2'b11, 1,32'h11,2'b01,2'b10,3'd1,1));
        vecs.push_back(mk(1,1,0,32'h33,2'b11,2'b00, 1,32'h11,2'b01,2'b10,3'd2,1));
        vecs.push_back(mk(1,1,0,32'h44,2'b00,2'b01, 1,32'h11,2'b01,2'b10,3'd3,1));
        vecs.push_back(mk(1,1,0,32'h55,2'b11,2'b11, 1,32'h11,2'b01,2'b10,3'd4,0));
        // Drain
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'h11,2'b01,2'b10,3'd4,0));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'h22,2'b10,2'b11,3'd3,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'h33,2'b11,2'b00,3'd2,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'h44,2'b00,2'b01,3'd1,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        // Occupancy 2, then 10 cycles of push+pop
        vecs.push_back(mk(1,1,0,32'hA1,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        vecs.push_back(mk(1,1,0,32'hA2,2'b00,2'b00, 1,32'hA1,2'b00,2'b00,3'd1,1));
        vecs.push_back(mk(1,0,0,32'hB0,2'b00,2'b00, 1,32'hA1,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB1,2'b00,2'b00, 1,32'hA2,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB2,2'b00,2'b00, 1,32'hB0,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB3,2'b00,2'b00, 1,32'hB1,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB4,2'b00,2'b00, 1,32'hB2,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB5,2'b00,2'b00, 1,32'hB3,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB6,2'b00,2'b00, 1,32'hB4,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB7,2'b00,2'b00, 1,32'hB5,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB8,2'b00,2'b00, 1,32'hB6,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(1,0,0,32'hB9,2'b00,2'b00, 1,32'hB7,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'hB8,2'b00,2'b00,3'd2,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'hB9,2'b00,2'b00,3'd1,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        // Occupancy 3, flush with concurrent push and stall
        vecs.push_back(mk(1,1,0,32'hC1,2'b01,2'b01, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        vecs.push_back(mk(1,1,0,32'hC2,2'b01,2'b01, 1,32'hC1,2'b01,2'b01,3'd1,1));
        vecs.push_back(mk(1,1,0,32'hC3,2'b01,2'b01, 1,32'hC1,2'b01,2'b01,3'd2,1));
        vecs.push_back(mk(1,1,1,32'h99,2'b11,2'b11, 1,32'hC1,2'b01,2'b01,3'd3,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        vecs.push_back(mk(0,1,0,32'h0 ,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        // Predication/selection pass-through held under stall
        vecs.push_back(mk(1,1,0,32'hD1,2'b10,2'b01, 0,32'h0 ,2'b00,2'b00,3'd0,1));
        vecs.push_back(mk(0,1,0,32'h0 ,2'b00,2'b00, 1,32'hD1,2'b10,2'b01,3'd1,1));
        vecs.push_back(mk(0,1,0,32'h0 ,2'b00,2'b00, 1,32'hD1,2'b10,2'b01,3'd1,1));
        vecs.push_back(mk(0,1,0,32'h0 ,2'b00,2'b00, 1,32'hD1,2'b10,2'b01,3'd1,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 1,32'hD1,2'b10,2'b01,3'd1,1));
        vecs.push_back(mk(0,0,0,32'h0 ,2'b00,2'b00, 0,32'h0 ,2'b00,2'b00,3'd0,1));

        // Asynchronous reset state, no clock edge needed
        iReset_n = 1'b0;
        drive(0, 0, 0, '0, 2'b00, 2'b00);
        #2;
        check("reset_state", 0, '0, 2'b00, 2'b00, 3'd0, 1);
        @(negedge iClk);
        iReset_n = 1'b1;
        tick();

        // Queue two entries, then reset mid-cycle
        drive(1, 1, 0, 32'hE1, 2'b11, 2'b11);
        tick();
        drive(1, 1, 0, 32'hE2, 2'b11, 2'b11);
        tick();
        drive(0, 1, 0, '0, 2'b00, 2'b00);
        #1;
        check("pre_reset_level", 1, 32'hE1, 2'b11, 2'b11, 3'd2, 1);
        #2;
        iReset_n = 1'b0;
        #1;
        check("mid_reset_nop", 0, '0, 2'b00, 2'b00, 3'd0, 1);
        @(negedge iClk);
        iReset_n = 1'b1;
        tick();

        // Table vectors: drive, sample before the edge, then clock
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].valid, vecs[k].stall, vecs[k].flush,
                  vecs[k].ins, vecs[k].pred, vecs[k].sel);
            #2;
            check($sformatf("vec%0d", k), vecs[k].e_valid, vecs[k].e_ins,
                  vecs[k].e_pred, vecs[k].e_sel, vecs[k].e_level,
                  vecs[k].e_ready);
            tick();
        end

        // Push into empty buffer with no stall
        drive(1, 0, 0, 32'hAB, 2'b01, 2'b11);
        #2;
`ifdef PE_IBUF_BYPASS_EN
        check("bypass_same", 1, 32'hAB, 2'b01, 2'b11, 3'd0, 1);
`else
        check("bypass_same", 0, '0, 2'b00, 2'b00, 3'd0, 1);
`endif
        tick();
        drive(0, 0, 0, '0, 2'b00, 2'b00);
        #2;
`ifdef PE_IBUF_BYPASS_EN
        check("bypass_next", 0, '0, 2'b00, 2'b00, 3'd0, 1);
`else
        check("bypass_next", 1, 32'hAB, 2'b01, 2'b11, 3'd1, 1);
`endif
        tick();
        #2;
        check("bypass_drained", 0, '0, 2'b00, 2'b00, 3'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
